// File: rtl/exp_wrap_pkg.sv
// Shared definitions for the batched exponential wrapper: state encoding,
// default parameter values and the output-width derivation.
package exp_wrap_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int XW_DEF    = 16;
  localparam int IW_DEF    = 2;
  localparam int FW_DEF    = 16;
  localparam int UW_DEF    = 2;
  localparam int DEPTH_DEF = 4;
  localparam int CW_DEF    = 8;

  // Result width that holds {int, frac} shifted by the largest possible u.
  function automatic int calc_ow(input int iw, input int fw, input int uw);
    return iw + fw + (2 ** uw) - 1;
  endfunction

endpackage

// File: rtl/exp_batch_wrapper_sample_fifo.sv
// Small sample FIFO with first-word-fall-through read data.
// Pointers carry one extra wrap bit to tell full from empty.
module sample_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_dout
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_wr_en;
  logic         w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/exp_batch_wrapper.sv
// Batched front end for the exponential engine: queues (x, u) samples and
// runs batch_len of them through the engine, emitting shifted results.
//
// state   | meaning
// IDLE    | waiting for w_start
// FETCH   | pop next sample (parks while FIFO empty)
// ISSUE   | eng_start pulse
// WAIT    | waiting for eng_done, capture shifted result
// WRITE   | wr_reg pulse with wr_addr = index
// DONE    | w_done pulse
module exp_batch_wrapper
  import exp_wrap_pkg::*;
#(
  parameter int XW    = XW_DEF,
  parameter int IW    = IW_DEF,
  parameter int FW    = FW_DEF,
  parameter int UW    = UW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [XW-1:0]                 in_x,
  input  logic [UW-1:0]                 in_u,
  input  logic                          w_start,
  input  logic [CW-1:0]                 batch_len,
  output logic                          busy,
  output logic                          w_done,
  output logic                          eng_start,
  output logic [XW-1:0]                 eng_x,
  input  logic                          eng_done,
  input  logic [IW-1:0]                 eng_int,
  input  logic [FW-1:0]                 eng_frac,
  output logic                          wr_reg,
  output logic [CW-1:0]                 wr_addr,
  output logic [calc_ow(IW,FW,UW)-1:0]  wr_data
);

  localparam int OW = calc_ow(IW, FW, UW);
  localparam int SW = XW + UW;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_index;
  logic [CW-1:0] r_wr_addr;
  logic [UW-1:0] r_u;
  logic [XW-1:0] r_eng_x;
  logic [OW-1:0] r_wr_data;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [SW-1:0] w_fifo_dout;
  logic [OW-1:0] w_shifted;
  logic          w_last;

  assign in_ready  = !w_full;
  assign w_pop     = (r_state == S_FETCH) && !w_empty;
  assign w_shifted = OW'({eng_int, eng_frac}) << r_u;
  assign w_last    = (r_index == r_len - CW'(1));

  sample_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_pop   (w_pop),
    .i_din   ({in_x, in_u}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (w_fifo_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = (batch_len == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (!w_empty) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (eng_done) w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len     <= '0;
      r_index   <= '0;
      r_wr_addr <= '0;
      r_u       <= '0;
      r_eng_x   <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start && batch_len != '0) begin
          r_len   <= batch_len;
          r_index <= '0;
        end
        S_FETCH: if (!w_empty) begin
          r_eng_x <= w_fifo_dout[SW-1:UW];
          r_u     <= w_fifo_dout[UW-1:0];
        end
        // Address is captured with the data so both hold until the next write.
        S_WAIT: if (eng_done) begin
          r_wr_data <= w_shifted;
          r_wr_addr <= r_index;
        end
        S_WRITE: if (!w_last) r_index <= r_index + CW'(1);
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_done    = (r_state == S_DONE);
  assign eng_start = (r_state == S_ISSUE);
  assign wr_reg    = (r_state == S_WRITE);
  assign eng_x     = r_eng_x;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule
